// File: rtl/addsub_pipe_param.sv
// addsub_pipe_param: NUM_STG-stage segmented add/subtract pipeline with stall, carry/borrow and signed overflow.
module addsub_pipe_param #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_STG    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_sub,
    input  logic [DATA_WIDTH-1:0] adda,
    input  logic [DATA_WIDTH-1:0] addb,
    input  logic                  i_stall,
    output logic [DATA_WIDTH:0]   result,
    output logic                  o_ovf,
    output logic                  o_en
);
    localparam int SEG_WIDTH = DATA_WIDTH / NUM_STG;

    if (NUM_STG < 1 || NUM_STG > DATA_WIDTH || DATA_WIDTH % NUM_STG != 0) begin : g_bad_cfg
        $error("addsub_pipe_param: DATA_WIDTH must be a multiple of NUM_STG, 1 <= NUM_STG <= DATA_WIDTH");
    end

    // Each stage consumes the low segment of its operand words and rotates its
    // sum segment in at the top, so after NUM_STG stages the A word is the
    // de-skewed sum and the unconsumed operand segments form the skew delay.
    logic [DATA_WIDTH-1:0] a_d [NUM_STG];
    logic [DATA_WIDTH-1:0] a_q [NUM_STG];
    logic [DATA_WIDTH-1:0] b_d [NUM_STG];
    logic [DATA_WIDTH-1:0] b_q [NUM_STG];
    logic [NUM_STG-1:0]    vld_d, vld_q, sub_d, sub_q, cy_d, cy_q;
    logic                  ovf_d, ovf_q;
    logic [DATA_WIDTH-1:0] pa, pb;
    logic [SEG_WIDTH-1:0]  bx, seg;
    logic                  pv, ps, pc, c;
    int                    p;

    always_comb begin
        vld_d = vld_q;
        sub_d = sub_q;
        cy_d  = cy_q;
        a_d   = a_q;
        b_d   = b_q;
        ovf_d = ovf_q;
        {pa, pb, bx, seg, pv, ps, pc, c, p} = '0;
        for (int k = 0; k < NUM_STG; k++) begin
            p  = (k + NUM_STG - 1) % NUM_STG;
            pv = k == 0 ? i_en  : vld_q[p];
            ps = k == 0 ? i_sub : sub_q[p];
            pc = k == 0 ? i_sub : cy_q[p];
            pa = k == 0 ? adda  : a_q[p];
            pb = k == 0 ? addb  : b_q[p];
            bx = pb[SEG_WIDTH-1:0] ^ {SEG_WIDTH{ps}};
            {c, seg} = {1'b0, pa[SEG_WIDTH-1:0]} + {1'b0, bx} + {{SEG_WIDTH{1'b0}}, pc};
            // The output valid is dropped on a stalled edge so a pulse is never repeated.
            vld_d[k] = i_stall ? (k != NUM_STG - 1) && vld_q[k] : pv;
            if (pv && !i_stall) begin
                sub_d[k] = ps;
                cy_d[k]  = c;
                a_d[k]   = DATA_WIDTH'({seg, pa} >> SEG_WIDTH);
                b_d[k]   = pb >> SEG_WIDTH;
                if (k == NUM_STG - 1) ovf_d = c ^ pa[SEG_WIDTH-1] ^ bx[SEG_WIDTH-1] ^ seg[SEG_WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            sub_q <= '0;
            cy_q  <= '0;
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            sub_q <= sub_d;
            cy_q  <= cy_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ovf_q <= ovf_d;
        end
    end

    assign result = {cy_q[NUM_STG-1] ^ sub_q[NUM_STG-1], a_q[NUM_STG-1]};
    assign o_ovf  = ovf_q;
    assign o_en   = vld_q[NUM_STG-1] && !i_stall;
endmodule

// File: tb/tb_addsub_pipe_param.sv
// tb_addsub_pipe_param: drives four width/stage configurations of addsub_pipe_param
// against an arithmetic reference model with a scoreboard keyed on un-stalled edges.
module tb_addsub_pipe_param;
    localparam int NCFG = 4;
    localparam int WS [NCFG]  = '{64, 32, 48, 128};
    localparam int NSS [NCFG] = '{4, 1, 3, 8};

    logic clk = 1'b0;
    int checks = 0, errors = 0, done_cnt = 0;

    always #5 clk = ~clk;

    task automatic chk(string nm, int id, logic [129:0] got, logic [129:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cfg%0d: got %h expected %h", nm, id, got, want);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = WS[g];
        localparam int N = NSS[g];
        logic         rst = 1'b1, i_en = 1'b0, i_sub = 1'b0, i_stall = 1'b0;
        logic [W-1:0] adda = '0, addb = '0;
        logic [W:0]   result;
        logic         o_ovf, o_en;
        logic [W+1:0] exp_q [$];
        int           tag_q [$];
        logic [W+1:0] last = '0;
        int           ue = 0;

        addsub_pipe_param #(.DATA_WIDTH(W), .NUM_STG(N)) dut (
            .clk(clk), .rst(rst), .i_en(i_en), .i_sub(i_sub), .adda(adda), .addb(addb),
            .i_stall(i_stall), .result(result), .o_ovf(o_ovf), .o_en(o_en)
        );

        // Returns {ovf, borrow/carry, difference/sum} from plain integer arithmetic.
        function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic s);
            logic [W:0] r;
            logic v;
            r = s ? {a < b, a - b} : {1'b0, a} + {1'b0, b};
            v = (s ? a[W-1] != b[W-1] : a[W-1] == b[W-1]) && r[W-1] != a[W-1];
            return {v, r};
        endfunction

        function automatic logic [W-1:0] rnd();
            logic [127:0] x = {$urandom, $urandom, $urandom, $urandom};
            return $urandom_range(0, 4) == 0 ? {W{1'b1}} : x[W-1:0];
        endfunction

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic drive(logic e, logic s, logic st, logic [W-1:0] a, logic [W-1:0] b);
            i_en = e; i_sub = s; i_stall = st; adda = a; addb = b;
        endtask

        task automatic pin(string nm, logic [W-1:0] a, logic [W-1:0] b, logic s, logic [W+1:0] want);
            int n = 0;
            drive(1'b1, s, 1'b0, a, b);
            do begin
                @(posedge clk);
                n++;
                #1 i_en = 1'b0;
                @(negedge clk);
            end while (!o_en && n < 50);
            chk({nm, "_latency"}, g, 130'(n), 130'(N));
            chk(nm, g, 130'({o_ovf, result}), 130'(want));
            step();
        endtask

        initial forever begin
            @(posedge clk);
            if (!rst && !i_stall) begin
                ue++;
                if (i_en) begin
                    exp_q.push_back(model(adda, addb, i_sub));
                    tag_q.push_back(ue);
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (rst) chk("reset_out", g, 130'({o_en, o_ovf, result}), 130'(0));
            else if (tag_q.size() > 0 && ue - tag_q[0] == N - 1) begin
                chk(i_stall ? "stalled_no_pulse" : "due_pulse", g, 130'(o_en), 130'(!i_stall));
                chk("result", g, 130'({o_ovf, result}), 130'(exp_q[0]));
                last = exp_q.pop_front();
                void'(tag_q.pop_front());
            end else chk("idle_hold", g, 130'({o_en, o_ovf, result}), 130'({1'b0, last}));
        end

        initial begin
            repeat (3) step();
            rst = 1'b0;
            step();
            pin("half_carry", {W{1'b1}} >> (W / 2), W'(1), 1'b0, (W + 2)'(1) << (W / 2));
            pin("full_ripple", {W{1'b1}}, W'(1), 1'b0, (W + 2)'(1) << W);
            pin("add_ovf", {1'b0, {(W - 1){1'b1}}}, W'(1), 1'b0,
                ((W + 2)'(1) << (W + 1)) | ((W + 2)'(1) << (W - 1)));
            pin("sub_borrow", W'(5), W'(7), 1'b1, {1'b0, 1'b1, {(W - 1){1'b1}}, 1'b0});
            pin("sub_ovf", W'(1) << (W - 1), W'(1), 1'b1, {2'b10, 1'b0, {(W - 1){1'b1}}});
            for (int i = 0; i < 8; i++) begin
                drive(1'b1, i[0], 1'b0, rnd(), rnd());
                step();
            end
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            repeat (N + 2) step();
            drive(1'b1, 1'b0, 1'b0, rnd(), rnd());
            step();
            drive(1'b1, 1'b1, 1'b0, rnd(), rnd());
            step();
            drive(1'b1, 1'b0, 1'b1, rnd(), rnd());
            repeat (5) step();
            i_stall = 1'b0;
            step();
            i_en = 1'b0;
            repeat (N + 8) step();
            repeat (300) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 6) == 0, rnd(), rnd());
                step();
            end
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            repeat (N + 4) step();
            drive(1'b1, 1'b1, 1'b0, rnd(), rnd());
            step();
            i_en = 1'b0;
            step();
            rst = 1'b1;
            exp_q.delete();
            tag_q.delete();
            last = '0;
            #1 chk("rst_async", g, 130'({o_en, o_ovf, result}), 130'(0));
            step();
            rst = 1'b0;
            repeat (2 * N + 4) step();
            done_cnt++;
        end
    end

    initial begin
        int cyc = 0;
        while (done_cnt < NCFG && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        checks++;
        if (done_cnt < NCFG) begin
            errors++;
            $display("FAIL timeout: %0d of %0d configs done", done_cnt, NCFG);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
